instr_fetch: RTL
================

# instr_fetch

Instruction fetch and prefetch stage for the stack processor. It sits directly upstream of the control unit. It owns the fetch program counter and issues reads to the synchronous program memory. Each 16-bit word is split into opcode (upper byte) and argument (lower byte) and buffered in a 2-entry prefetch queue, which the control unit drains with a valid/ack handshake. Jumps from the control unit flush the queue and redirect fetch.

## Interface
Parameters:
- DATA_WIDTH, 8, width of opcode and argument fields
- ADDR_WIDTH, 12, program memory address width
- INSTRUCTION_WIDTH, 16, program word width; must equal 2*DATA_WIDTH

Ports:
- clk  input  1  single clock; all state changes on rising edge
- reset  input  1  synchronous, active-low reset
- MEM_ADDR  output  ADDR_WIDTH  program memory read address
- MEM_RD  output  1  read strobe; data returns on MEM_DATA_IN exactly one cycle later
- MEM_DATA_IN  input  INSTRUCTION_WIDTH  program word from memory
- JUMP_EN  input  1  redirect fetch to JUMP_ADDR (one-cycle pulse from control unit)
- JUMP_ADDR  input  ADDR_WIDTH  jump target
- INSTR_OUT  output  DATA_WIDTH  opcode of queue head, MEM_DATA_IN[15:8] at capture
- ARG_OUT  output  DATA_WIDTH  argument of queue head, MEM_DATA_IN[7:0] at capture
- PC_OUT  output  ADDR_WIDTH  address the queue-head word was fetched from
- INSTR_VALID  output  1  queue head holds a valid instruction
- INSTR_ACK  input  1  control unit consumes head; ignored when INSTR_VALID=0

## Operation
- State:
  - fetch PC (fpc)
  - 2-entry queue of {opcode, arg, addr}
  - count (0..2)
  - inflight flag (a read was issued last cycle)
  - FSM with states BOOT and RUN
- Reset (reset=0 at an edge):
  - fpc=0, count=0, inflight=0, FSM=BOOT.
  - Outputs: MEM_ADDR=0, MEM_RD=0, INSTR_OUT=0, ARG_OUT=0, PC_OUT=0, INSTR_VALID=0.
  - Reset mid-operation discards queue contents and any in-flight read; the returning word is never enqueued.
- BOOT: MEM_RD=0 for exactly one cycle, then RUN unconditionally.
- RUN, pop: pop = INSTR_VALID & INSTR_ACK & ~JUMP_EN.
- RUN, issue rule: MEM_RD=1 when (count + inflight − pop) < 2 and JUMP_EN=0.
  - MEM_ADDR=fpc.
  - fpc increments by 1 per issued read, wrapping 2^ADDR_WIDTH−1 → 0.
- Capture: when inflight=1 and JUMP_EN=0, MEM_DATA_IN is written at the queue tail at the end of that cycle, tagged with the address that was read.
- Simultaneous capture and pop: count is unchanged and the head advances.
- Queue full (count=2): no issue unless pop occurs in the same cycle. The issue rule guarantees a capture never overflows.
- Queue empty: INSTR_VALID=0. INSTR_OUT, ARG_OUT and PC_OUT hold their last values (don't-care for consumer).
- Jump (JUMP_EN=1 in RUN):
  - Queue cleared (count=0), MEM_RD=0.
  - Word arriving this cycle is dropped; inflight cleared.
  - fpc=JUMP_ADDR; pop suppressed, even if INSTR_ACK=1.
  - JUMP_EN in BOOT has the same effect.
- Jump to 2^ADDR_WIDTH−1: fetch continues at 0 after it.

## Timing
- Memory read latency: 1 cycle. Enqueue happens at the end of the data cycle; INSTR_VALID rises the next cycle.
- Reset release (reset=1 first seen at edge e0):
  - cycle after e0 is BOOT.
  - first read of addr 0 is in cycle +2.
  - first INSTR_VALID=1 is in cycle +4.
- Jump at cycle t:
  - MEM_RD=1 with MEM_ADDR=JUMP_ADDR at t+1.
  - data at t+2.
  - INSTR_VALID=1 with the target word at t+3.
- Steady state with INSTR_ACK held 1: one instruction per cycle, no bubbles.
- Handshake: INSTR_OUT, ARG_OUT and PC_OUT are stable while INSTR_VALID=1 and INSTR_ACK=0.

## Test plan
- Reset/boot:
  - Stimulus: memory[0..2] = 0x0100, 0x0203, 0x0305; reset low 3 cycles; ACK=1.
  - Required: all outputs 0 during reset; MEM_RD first high 2 cycles after release; INSTR_VALID at +4 with INSTR_OUT=0x01, ARG_OUT=0x00, PC_OUT=0; then 0x02/0x03 and 0x03/0x05 on consecutive cycles.
- Backpressure:
  - Stimulus: ACK=0 from start.
  - Required: exactly 2 reads issued (addr 0, 1), then MEM_RD=0; head holds 0x01/0x00 stable. ACK=1 for one cycle → head becomes 0x02/0x03, one read at addr 2.
- Jump flush:
  - Stimulus: during steady streaming, JUMP_EN=1 with JUMP_ADDR=0x040 and ACK=1 in the same cycle.
  - Required: no pop; MEM_RD=0 that cycle; next cycle MEM_ADDR=0x040; INSTR_VALID=0 for 2 cycles, then PC_OUT=0x040. No word from the old stream is ever presented.
- Wrap-around:
  - Stimulus: jump to 0xFFF; memory[0xFFF]=0xAA11, memory[0]=0x0100.
  - Required: PC_OUT sequence 0xFFF, 0x000, 0x001 with the matching opcodes.
- Reset mid-operation:
  - Stimulus: reset=0 for 1 cycle while count=2 and a read is in flight.
  - Required: INSTR_VALID=0 next cycle; the returning word is dropped; fetch restarts at 0 per the boot timing.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch: program counter, memory read issue and 2-entry prefetch queue
module instr_fetch #(
    parameter int DATA_WIDTH        = 8,
    parameter int ADDR_WIDTH        = 12,
    parameter int INSTRUCTION_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic [ADDR_WIDTH-1:0]        MEM_ADDR,
    output logic                         MEM_RD,
    input  logic [INSTRUCTION_WIDTH-1:0] MEM_DATA_IN,
    input  logic                         JUMP_EN,
    input  logic [ADDR_WIDTH-1:0]        JUMP_ADDR,
    output logic [DATA_WIDTH-1:0]        INSTR_OUT,
    output logic [DATA_WIDTH-1:0]        ARG_OUT,
    output logic [ADDR_WIDTH-1:0]        PC_OUT,
    output logic                         INSTR_VALID,
    input  logic                         INSTR_ACK
);

    typedef enum logic {BOOT, RUN} state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] op;
        logic [DATA_WIDTH-1:0] arg;
        logic [ADDR_WIDTH-1:0] pc;
    } entry_t;

    state_t                state_q, state_d;
    logic                  armed_q, armed_d;
    logic [ADDR_WIDTH-1:0] fpc_q, fpc_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  inflight_q, inflight_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    entry_t                q0_q, q0_d;
    entry_t                q1_q, q1_d;

    logic                  pop;
    logic                  cap;
    logic                  issue;
    logic [2:0]            occ;
    logic [1:0]            tail;
    entry_t                new_e;

    // Head of the queue always lives in q0; it keeps its value when the queue drains
    assign INSTR_VALID = cnt_q != 2'd0;
    assign INSTR_OUT   = q0_q.op;
    assign ARG_OUT     = q0_q.arg;
    assign PC_OUT      = q0_q.pc;
    assign MEM_ADDR    = fpc_q;
    assign MEM_RD      = issue;

    // Next-state: BOOT idles one full cycle after reset release, jumps flush and redirect
    always_comb begin
        state_d    = state_q;
        armed_d    = 1'b1;
        pop        = INSTR_VALID & INSTR_ACK & ~JUMP_EN;
        cap        = inflight_q & ~JUMP_EN;
        occ        = {1'b0, cnt_q} + {2'b0, inflight_q} - {2'b0, pop};
        issue      = (state_q == RUN) & ~JUMP_EN & (occ < 3'd2);
        tail       = cnt_q - {1'b0, pop};
        new_e.op   = MEM_DATA_IN[2*DATA_WIDTH-1:DATA_WIDTH];
        new_e.arg  = MEM_DATA_IN[DATA_WIDTH-1:0];
        new_e.pc   = rd_addr_q;
        q0_d       = (pop && cnt_q == 2'd2) ? q1_q : q0_q;
        q1_d       = q1_q;
        if (cap && tail == 2'd0)
            q0_d = new_e;
        if (cap && tail != 2'd0)
            q1_d = new_e;
        cnt_d      = JUMP_EN ? 2'd0 : cnt_q - {1'b0, pop} + {1'b0, cap};
        inflight_d = issue;
        rd_addr_d  = fpc_q;
        fpc_d      = JUMP_EN ? JUMP_ADDR : fpc_q + ADDR_WIDTH'(issue);
        if (state_q == BOOT && armed_q)
            state_d = RUN;
    end

    // State registers; reset drops queue contents and any read still in flight
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= BOOT;
            armed_q    <= 1'b0;
            fpc_q      <= '0;
            cnt_q      <= 2'd0;
            inflight_q <= 1'b0;
            rd_addr_q  <= '0;
            q0_q       <= '0;
            q1_q       <= '0;
        end else begin
            state_q    <= state_d;
            armed_q    <= armed_d;
            fpc_q      <= fpc_d;
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
            rd_addr_q  <= rd_addr_d;
            q0_q       <= q0_d;
            q1_q       <= q1_d;
        end
    end

endmodule
